toy_lsu: RTL
============

# toy_lsu

Parametrised load/store unit between the RISC_TOY pipeline and the data-memory port. It queues load/store requests from the execute stage in a command FIFO, issues them in order to memory under a grant handshake, and returns tagged load data after a fixed memory read latency. This replaces the direct DREQ/DRW/DADDR/DWDATA drive from the EX register. It adds wait-state tolerance, multiple outstanding loads and back-pressure to the core.

## Interface
- AW, 30: word-address width.
- DW, 32: data width.
- TW, 5: tag width (destination register index).
- DEPTH, 4: command FIFO entries; power of 2, ≥2.
- RD_LAT, 1: memory read latency in cycles, legal range 1..4. The bench uses legal values only.

- CLK  in  1  clock; all state updates on the rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- req_valid  in  1  core request valid.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  AW  word address.
- req_wdata  in  DW  store data.
- req_tag  in  TW  load destination tag.
- rsp_valid  out  1  load data valid, one-cycle pulse.
- rsp_tag  out  TW  tag of the returned load.
- rsp_data  out  DW  load data.
- busy  out  1  FIFO non-empty or a read is in flight.
- DREQ  out  1  memory request.
- DRW  out  1  1 = write.
- DADDR  out  AW  memory word address.
- DWDATA  out  DW  memory write data.
- DGNT  in  1  memory accepts the request this cycle.
- DRDATA  in  DW  memory read data.

## Operation
- **Accept.** A request is accepted on an edge where req_valid && req_ready. Its {we, addr, wdata, tag} is pushed at the write pointer.
- **req_ready.** Combinational, equal to !full. There is no pass-through. A full FIFO refuses a push even on an edge where it pops.
- **Head presentation.** DREQ = !empty. DRW, DADDR and DWDATA come straight from the head entry. They stay stable while DREQ=1 and DGNT=0.
- **Issue.** An issue happens on an edge with DREQ && DGNT; the head is popped.
- **Read tracking.** An issued load enters stage 1 of an RD_LAT-deep valid+tag shift pipeline. Stores enter nothing and produce no response.
- **Response.** When stage RD_LAT is valid, DRDATA is sampled at that edge into rsp_data and rsp_tag, and rsp_valid=1 for exactly one cycle.
- **Ordering.** Responses come back strictly in issue order. There is no limit on outstanding loads beyond the pipeline depth.
- **Pointers.** Read and write pointers wrap modulo DEPTH. The count holds DEPTH+1 states (0..DEPTH).
  - Push and pop on the same edge: count unchanged.
  - Pop with no push: count − 1.
  - Push with no pop: count + 1.
- **busy.** busy = !empty || any pipeline stage valid.
- **Tags.** Tags pass through unmodified; tag 0 still gets a response.

## Timing
- **Reset values.**
  - FIFO empty, pointers 0, pipeline cleared.
  - DREQ=0, DRW=0, DADDR=0, DWDATA=0.
  - rsp_valid=0, rsp_tag=0, rsp_data=0, busy=0, req_ready=1.
- **Load latency.** A load accepted at edge e with an empty FIFO and DGNT=1:
  - DREQ is high in the cycle after e;
  - the load issues at edge e+1;
  - rsp_valid is high in the cycle after edge e+1+RD_LAT.
  - Total from acceptance: RD_LAT+2 edges.
- **Throughput.** One issue per cycle while DGNT=1. One response per cycle for back-to-back loads.
- **Reset mid-operation.** All queued and in-flight requests are dropped and no response is ever produced for them. Writes granted before the reset are considered complete.

## Test plan
- **Store then load, RD_LAT=1, DGNT=1.**
  - Stimulus: store addr 0x10 data 0xDEADBEEF tag 3, then load addr 0x10 tag 7 on the next cycle.
  - Required: DREQ with DRW=1 then DRW=0; one rsp_valid pulse with tag 7, data 0xDEADBEEF, 3 edges after the load is accepted; no response for the store.
- **Full FIFO, DEPTH=4, DGNT=0.**
  - Stimulus: offer 5 requests.
  - Required: req_ready falls after the 4th is accepted and the 5th is held; DREQ=1 with the head address stable.
  - Then raise DGNT. Required: one issue per cycle in order, and the 5th is accepted once a slot frees.
- **Back-to-back loads, RD_LAT=3.**
  - Stimulus: loads with tags 1..4 on consecutive cycles, DGNT=1.
  - Required: rsp_valid on 4 consecutive cycles with tags 1, 2, 3, 4.
- **Grant gaps.**
  - Stimulus: DGNT pattern 1,0,1,0 with 3 queued loads.
  - Required: issues occur only on DGNT=1 edges; responses spaced accordingly and in order.
- **Push/pop at count DEPTH−1.**
  - Stimulus: simultaneous push and pop.
  - Required: count unchanged, req_ready stays 1.
- **Reset mid-operation.**
  - Stimulus: RSTN low with 3 requests queued and 2 reads in flight.
  - Required: immediately DREQ=0, rsp_valid=0, busy=0, req_ready=1; no responses after release.

Source files
------------

// File: rtl/toy_lsu.sv
// rtl/toy_lsu.sv - load/store unit: in-order command FIFO, grant-handshake issue, fixed-latency load return
//
// Queues core load/store requests and presents the oldest one to the data-memory
// port. Loads that are granted travel down an RD_LAT-deep valid+tag pipeline so the
// returning DRDATA can be paired with its destination tag.
//
// Ports:
//   CLK, RSTN                  clock, asynchronous active-low reset
//   req_valid/req_ready        core request handshake
//   req_we/addr/wdata/tag      request payload (1 = store)
//   rsp_valid/rsp_tag/rsp_data load response, one-cycle pulse per load
//   busy                       FIFO non-empty or a load in flight
//   DREQ/DRW/DADDR/DWDATA      memory request, driven from the FIFO head
//   DGNT                       memory accepts the head this cycle
//   DRDATA                     memory read data, RD_LAT cycles after the grant
module toy_lsu #(
   parameter int AW     = 30,
   parameter int DW     = 32,
   parameter int TW     = 5,
   parameter int DEPTH  = 4,
   parameter int RD_LAT = 1
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   input  logic [TW-1:0] req_tag,
   output logic          rsp_valid,
   output logic [TW-1:0] rsp_tag,
   output logic [DW-1:0] rsp_data,
   output logic          busy,
   output logic          DREQ,
   output logic          DRW,
   output logic [AW-1:0] DADDR,
   output logic [DW-1:0] DWDATA,
   input  logic          DGNT,
   input  logic [DW-1:0] DRDATA
);

   localparam int PW = $clog2(DEPTH);

   logic          fifo_we    [DEPTH];
   logic [AW-1:0] fifo_addr  [DEPTH];
   logic [DW-1:0] fifo_wdata [DEPTH];
   logic [TW-1:0] fifo_tag   [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   logic [RD_LAT-1:0] pipe_vld;
   logic [TW-1:0]     pipe_tag [RD_LAT];

   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);

   // No pass-through: a full FIFO refuses even when the head pops this edge.
   assign req_ready = !full;
   assign push      = req_valid && !full;
   assign pop       = !empty && DGNT;

   // Head fields are masked while empty so the port idles at zero; storage itself
   // is never reset.
   assign DREQ   = !empty;
   assign DRW    = !empty && fifo_we[rd_ptr];
   assign DADDR  = empty ? '0 : fifo_addr[rd_ptr];
   assign DWDATA = empty ? '0 : fifo_wdata[rd_ptr];

   assign busy = !empty || (|pipe_vld);

   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_we[wr_ptr]    <= req_we;
         fifo_addr[wr_ptr]  <= req_addr;
         fifo_wdata[wr_ptr] <= req_wdata;
         fifo_tag[wr_ptr]   <= req_tag;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Stage RD_LAT-1 valid means DRDATA on the current edge belongs to that load.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         pipe_vld  <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe_tag[i] <= '0;
         rsp_valid <= 1'b0;
         rsp_tag   <= '0;
         rsp_data  <= '0;
      end else begin
         pipe_vld[0] <= pop && !fifo_we[rd_ptr];
         pipe_tag[0] <= fifo_tag[rd_ptr];
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_tag[i] <= pipe_tag[i-1];
         end
         rsp_valid <= pipe_vld[RD_LAT-1];
         if (pipe_vld[RD_LAT-1]) begin
            rsp_tag  <= pipe_tag[RD_LAT-1];
            rsp_data <= DRDATA;
         end
      end
   end

endmodule
